// File: rtl/serial_det_pkg.sv
// -----------------------------------------------------------------------------
// serial_det_pkg
//   Shared definitions for the serial pattern detector: the FSM state type
//   and the default detector configuration.
// -----------------------------------------------------------------------------
package serial_det_pkg;

  // FILL: window still collecting bits; ARMED: window holds PAT_W valid bits
  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } det_state_e;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_OVERLAP = 1;
  localparam int         DEF_CNT_W   = 8;

endpackage

// File: rtl/serial_pattern_detector_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that stops at all-ones instead of wrapping.
// Ports
//   clk    in  1      rising-edge clock
//   rst    in  1      synchronous reset, active-high, clears count
//   inc    in  1      advance the count by one when not already at maximum
//   count  out CNT_W  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  // Count register: clear on reset, advance on inc, hold at maximum
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/serial_pattern_detector.sv
// -----------------------------------------------------------------------------
// serial_pattern_detector
//   Watches a qualified serial bit stream and flags every occurrence of a
//   fixed PAT_W-bit pattern (MSB = oldest bit). A registered one-cycle pulse
//   marks each match and a saturating counter tracks matches since reset.
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in         in   1      serial data bit
//   in_valid   in   1      qualifies in; bit is sampled only when 1
//   match      out  1      one-cycle pulse per detected pattern (registered)
//   match_cnt  out  CNT_W  matches since reset, saturating at all-ones
//   primed     out  1      window holds PAT_W valid bits
// -----------------------------------------------------------------------------
module serial_pattern_detector
  import serial_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               OVERLAP = DEF_OVERLAP,
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             primed
);

  localparam int            FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic          RESTART_ON_HIT = (OVERLAP == 0);

  logic [PAT_W-1:0]  r_win;
  logic [FILL_W-1:0] r_fill;
  det_state_e        r_state;
  logic              r_match;

  logic [PAT_W-1:0]  w_win_shift;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_hit;
  logic [PAT_W-1:0]  w_win_nxt;
  logic [FILL_W-1:0] w_fill_nxt;
  det_state_e        w_state_nxt;

  assign w_win_shift = {r_win[PAT_W-2:0], in};
  assign w_fill_inc  = (r_fill == FILL_FULL) ? FILL_FULL : (r_fill + FILL_ONE);
  // A hit needs a full window of real samples, so reset zeros never match
  assign w_hit       = in_valid && (w_fill_inc == FILL_FULL) && (w_win_shift == PATTERN);

  // Next-state logic for window, fill level and FSM state
  always_comb begin
    w_win_nxt   = r_win;
    w_fill_nxt  = r_fill;
    w_state_nxt = r_state;
    if (!in_valid) begin
      w_win_nxt   = r_win;
      w_fill_nxt  = r_fill;
      w_state_nxt = r_state;
    end else if (w_hit && RESTART_ON_HIT) begin
      // Non-overlapping mode: the window still loads the bit, but the next
      // match must be built entirely from fresh samples
      w_win_nxt   = w_win_shift;
      w_fill_nxt  = {FILL_W{1'b0}};
      w_state_nxt = FILL;
    end else begin
      w_win_nxt  = w_win_shift;
      w_fill_nxt = w_fill_inc;
      case (r_state)
        FILL: begin
          if (w_fill_inc == FILL_FULL) begin
            w_state_nxt = ARMED;
          end else begin
            w_state_nxt = FILL;
          end
        end
        ARMED:   w_state_nxt = ARMED;
        default: w_state_nxt = FILL;
      endcase
    end
  end

  // Window, fill, state and match pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win   <= {PAT_W{1'b0}};
      r_fill  <= {FILL_W{1'b0}};
      r_state <= FILL;
      r_match <= 1'b0;
    end else begin
      r_win   <= w_win_nxt;
      r_fill  <= w_fill_nxt;
      r_state <= w_state_nxt;
      r_match <= w_hit;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_hit),
    .count (match_cnt)
  );

  assign match  = r_match;
  assign primed = (r_state == ARMED);

endmodule

// File: tb/tb_serial_pattern_detector.sv
// -----------------------------------------------------------------------------
// Bench for serial_pattern_detector. Five instances with different
// configurations share one stimulus stream; a reference model built on the
// count of valid bits since the last restart predicts each instance's outputs.
// -----------------------------------------------------------------------------
module tb_serial_pattern_detector;

  localparam int NI = 5;

  typedef struct packed {
    logic [NI-1:0]      m;
    logic [NI-1:0]      p;
    logic [NI-1:0][7:0] c;
  } exp_t;

  logic clk;
  logic rst;
  logic din;
  logic in_valid;

  logic       m_a, m_b, m_c, m_d, m_e;
  logic       p_a, p_b, p_c, p_d, p_e;
  logic [7:0] c_a, c_b, c_d, c_e;
  logic [1:0] c_c;

  serial_pattern_detector u_a (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid),
    .match(m_a), .match_cnt(c_a), .primed(p_a));

  serial_pattern_detector #(.OVERLAP(0)) u_b (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid),
    .match(m_b), .match_cnt(c_b), .primed(p_b));

  serial_pattern_detector #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid),
    .match(m_c), .match_cnt(c_c), .primed(p_c));

  serial_pattern_detector #(.PATTERN(4'b0000)) u_d (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid),
    .match(m_d), .match_cnt(c_d), .primed(p_d));

  serial_pattern_detector #(.PATTERN(4'b1111)) u_e (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid),
    .match(m_e), .match_cnt(c_e), .primed(p_e));

  // Reference configuration per instance
  int pat  [NI] = '{11, 11, 11, 0, 15};
  int ovl  [NI] = '{1, 0, 1, 1, 1};
  int cmax [NI] = '{255, 255, 3, 255, 255};

  // Reference state: last four sampled bits, bits since restart, matches
  int last4;
  int since [NI];
  int cnt   [NI];

  exp_t sb[$];
  int   tests;
  int   fails;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Predict outputs after an edge with the given inputs and queue them
  task automatic model(input bit r, input bit v, input bit b);
    exp_t e;
    bit   hit;
    e = '0;
    if (r) begin
      last4 = 0;
    end else if (v) begin
      last4 = ((last4 << 1) | int'(b)) & 15;
    end
    for (int i = 0; i < NI; i++) begin
      hit = 1'b0;
      if (r) begin
        since[i] = 0;
        cnt[i]   = 0;
      end else if (v) begin
        since[i] = since[i] + 1;
        if (since[i] >= 4 && last4 == pat[i]) begin
          hit = 1'b1;
          if (cnt[i] < cmax[i]) cnt[i] = cnt[i] + 1;
          if (ovl[i] == 0) since[i] = 0;
        end
      end
      e.m[i] = hit;
      e.p[i] = (since[i] >= 4);
      e.c[i] = 8'(cnt[i]);
    end
    sb.push_back(e);
  endtask

  // Drive one cycle of stimulus and record what the outputs should become
  task automatic step(input bit r, input bit v, input bit b);
    rst      = r;
    in_valid = v;
    din      = b;
    @(posedge clk);
    model(r, v, b);
    #1;
  endtask

  task automatic bits4(input bit [3:0] nib);
    for (int k = 3; k >= 0; k--) step(1'b0, 1'b1, nib[k]);
  endtask

  // Monitor: compare DUT outputs against queued expectations mid-cycle
  always @(negedge clk) begin
    exp_t       e;
    logic [NI-1:0]      gm;
    logic [NI-1:0]      gp;
    logic [NI-1:0][7:0] gc;
    cyc = cyc + 1;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      gm = {m_e, m_d, m_c, m_b, m_a};
      gp = {p_e, p_d, p_c, p_b, p_a};
      gc = {c_e, c_d, {6'd0, c_c}, c_b, c_a};
      for (int i = 0; i < NI; i++) begin
        tests = tests + 3;
        if (gm[i] !== e.m[i]) begin
          fails = fails + 1;
          $display("FAIL match[%0d] cyc %0d: got %0b want %0b", i, cyc, gm[i], e.m[i]);
        end
        if (gp[i] !== e.p[i]) begin
          fails = fails + 1;
          $display("FAIL primed[%0d] cyc %0d: got %0b want %0b", i, cyc, gp[i], e.p[i]);
        end
        if (gc[i] !== e.c[i]) begin
          fails = fails + 1;
          $display("FAIL match_cnt[%0d] cyc %0d: got %0d want %0d", i, cyc, gc[i], e.c[i]);
        end
      end
    end
  end

  initial begin
    bit r;
    bit v;
    bit b;
    int waits;
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    last4    = 0;
    for (int i = 0; i < NI; i++) begin
      since[i] = 0;
      cnt[i]   = 0;
    end
    rst      = 1'b1;
    in_valid = 1'b1;
    din      = 1'b0;

    // Reset with toggling input
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    // Single pattern
    bits4(4'b1011);
    // Overlapping vs restarting: 1011011
    step(1'b1, 1'b0, 1'b0);
    bits4(4'b1011);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    // Gap in valid with in held high
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    // Five separate frames: exercises saturation of the 2-bit counter
    step(1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 5; f++) begin
      bits4(4'b1011);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    // Partial pattern discarded by reset
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    // All-zero pattern needs four real zeros after reset
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0);
    // Run of ones for back-to-back matches
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b1);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      step(r, v, b);
    end
    step(1'b0, 1'b0, 1'b0);

    waits = 0;
    while (sb.size() > 0 && waits < 5) begin
      @(posedge clk);
      waits = waits + 1;
    end
    tests = tests + 1;
    if (sb.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
